// File: rtl/slc3_io_pkg.sv
// slc3_io_pkg: key FSM state encoding, default debounce length and stability counter width
package slc3_io_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int CNT_W = 16;
endpackage

// File: rtl/slc3_input_conditioner_if.sv
// slc3_input_conditioner_if: raw keys/switches in (master drives), debounced pulses/levels and synced switches out (slave drives)
interface slc3_input_conditioner_if #(parameter int SW_WIDTH = 10);
  logic Run_key;
  logic Continue_key;
  logic [SW_WIDTH-1:0] SW_raw;
  logic Run_pulse;
  logic Continue_pulse;
  logic Run_held;
  logic Continue_held;
  logic [SW_WIDTH-1:0] SW_sync;
  modport master (
    output Run_key, Continue_key, SW_raw,
    input Run_pulse, Continue_pulse, Run_held, Continue_held, SW_sync
  );
  modport slave (
    input Run_key, Continue_key, SW_raw,
    output Run_pulse, Continue_pulse, Run_held, Continue_held, SW_sync
  );
endinterface

// File: rtl/key_debouncer.sv
// key_debouncer: one active-low key -> 2-flop sync (rst_n), debounce FSM/counter (fsm_rst_n), outputs pulse (one cycle per press) and held level
module key_debouncer
  import slc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fsm_rst_n,
  input  logic key,
  output logic pulse,
  output logic held
);
  logic [1:0] sync_q;
  logic pressed;
  logic done;
  logic [CNT_W-1:0] cnt;
  key_state_t state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], key};
  assign pressed = ~sync_q[1];
  assign done = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or negedge fsm_rst_n)
    if (!fsm_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pulse <= 1'b0;
      held <= 1'b0;
    end else begin
      pulse <= state == HELD && !held;
      held <= state == HELD || state == RELEASE_WAIT;
      case (state)
        IDLE:
          if (pressed) begin
            state <= PRESS_WAIT;
            cnt <= '0;
          end
        PRESS_WAIT:
          if (!pressed) begin
            state <= IDLE;
            cnt <= '0;
          end else if (done) begin
            state <= HELD;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
        HELD:
          if (!pressed) begin
            state <= RELEASE_WAIT;
            cnt <= '0;
          end
        RELEASE_WAIT:
          if (pressed) begin
            state <= HELD;
            cnt <= '0;
          end else if (done) begin
            state <= IDLE;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
      endcase
    end
endmodule

// File: rtl/slc3_input_conditioner.sv
// slc3_input_conditioner: Clk, async active-low Reset, io slave port; debounces Run/Continue keys and two-flop syncs the switches
module slc3_input_conditioner
  import slc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SW_WIDTH = 10
) (
  input logic Clk,
  input logic Reset,
  slc3_input_conditioner_if.slave io
);
  logic [1:0] rst_q;
  logic [SW_WIDTH-1:0] sw_q;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      sw_q <= '0;
      io.SW_sync <= '0;
    end else begin
      sw_q <= io.SW_raw;
      io.SW_sync <= sw_q;
    end
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(Clk),
    .rst_n(Reset),
    .fsm_rst_n(rst_q[1]),
    .key(io.Run_key),
    .pulse(io.Run_pulse),
    .held(io.Run_held)
  );
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_continue (
    .clk(Clk),
    .rst_n(Reset),
    .fsm_rst_n(rst_q[1]),
    .key(io.Continue_key),
    .pulse(io.Continue_pulse),
    .held(io.Continue_held)
  );
endmodule

// File: tb/tb_slc3_input_conditioner.sv
// tb_slc3_input_conditioner: run-length reference model plus directed literal checks and random stimulus
module tb_slc3_input_conditioner;
  localparam int D = 4;
  localparam int W = 10;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  slc3_input_conditioner_if #(.SW_WIDTH(W)) io ();
  slc3_input_conditioner #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(W)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .io(io)
  );
  always #5 Clk = ~Clk;
  int tests = 0, fails = 0, cyc = 0;
  bit chk_en = 0;
  always @(posedge Clk) cyc++;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // Model: accepted level flips once D+1 consecutive synchronised samples disagree with it;
  // held shows the accepted level one cycle later, pulse marks the cycle after a 0->1 acceptance.
  bit kd1[2], kd2[2], lvl[2], m_held[2], m_pulse[2];
  int run[2];
  int age;
  logic [W-1:0] sw1, sw2;
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < 2; k++) begin
        kd1[k] = 1; kd2[k] = 1; lvl[k] = 0; m_held[k] = 0; m_pulse[k] = 0; run[k] = 0;
      end
      sw1 = '0; sw2 = '0; age = 0;
    end else begin
      bit p;
      if (age >= 2)
        for (int k = 0; k < 2; k++) begin
          m_pulse[k] = lvl[k] && !m_held[k];
          m_held[k] = lvl[k];
          p = !kd2[k];
          if (p == lvl[k]) run[k] = 0;
          else begin
            run[k]++;
            if (run[k] == D + 1) begin
              lvl[k] = p;
              run[k] = 0;
            end
          end
        end
      kd2 = kd1;
      kd1[0] = io.Run_key;
      kd1[1] = io.Continue_key;
      sw2 = sw1;
      sw1 = io.SW_raw;
      if (age < 2) age++;
    end
  end
  int run_np = 0, cont_np = 0, run_pc = -1, cont_pc = -1, run_fall = -1, run_falls = 0, cont_rises = 0;
  bit run_h_q = 0, cont_h_q = 0;
  always @(negedge Clk) begin
    if (chk_en) begin
      check("run_pulse", int'(io.Run_pulse), int'(m_pulse[0]));
      check("cont_pulse", int'(io.Continue_pulse), int'(m_pulse[1]));
      check("run_held", int'(io.Run_held), int'(m_held[0]));
      check("cont_held", int'(io.Continue_held), int'(m_held[1]));
      check("sw_sync", int'(io.SW_sync), int'(sw2));
    end
    if (io.Run_pulse) begin run_np++; run_pc = cyc; end
    if (io.Continue_pulse) begin cont_np++; cont_pc = cyc; end
    if (!io.Run_held && run_h_q) begin run_falls++; run_fall = cyc; end
    if (io.Continue_held && !cont_h_q) cont_rises++;
    run_h_q = io.Run_held;
    cont_h_q = io.Continue_held;
  end
  task automatic step(input int n);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask
  task automatic check_all_zero(input string name);
    check({name, "_outs"}, int'({io.Run_pulse, io.Continue_pulse, io.Run_held, io.Continue_held}), 0);
    check({name, "_sw"}, int'(io.SW_sync), 0);
  endtask
  initial begin
    int c, r, np0, cp0, f0, cr0;
    io.Run_key = 1; io.Continue_key = 1; io.SW_raw = '0;
    #1 Reset = 0;
    #1 chk_en = 1;
    check_all_zero("reset");
    io.SW_raw = 10'h006;
    step(3);
    Reset = 1;
    step(1);
    check("sw_one_edge", int'(io.SW_sync), 0);
    step(1);
    check("sw_two_edges", int'(io.SW_sync), 6);
    check("idle_outs", int'({io.Run_pulse, io.Continue_pulse, io.Run_held, io.Continue_held}), 0);
    step(5);
    np0 = run_np; f0 = run_falls; c = cyc;
    io.Run_key = 0;
    step(20);
    check("model_held_pin", int'(m_held[0]), 1);
    io.Run_key = 1; r = cyc;
    step(20);
    check("press_pulses", run_np - np0, 1);
    check("press_latency", run_pc, c + 8);
    check("release_latency", run_fall, r + 8);
    check("release_falls", run_falls - f0, 1);
    cp0 = cont_np; cr0 = cont_rises;
    io.Continue_key = 0; step(2);
    io.Continue_key = 1; step(1);
    io.Continue_key = 0; step(2);
    io.Continue_key = 1; step(20);
    check("bounce_pulses", cont_np - cp0, 0);
    check("bounce_held", cont_rises - cr0, 0);
    np0 = run_np; cp0 = cont_np;
    io.Run_key = 0; io.Continue_key = 0;
    step(10);
    io.Run_key = 1; io.Continue_key = 1;
    step(20);
    check("both_run_pulses", run_np - np0, 1);
    check("both_cont_pulses", cont_np - cp0, 1);
    check("both_same_cycle", run_pc, cont_pc);
    np0 = run_np;
    io.Run_key = 0;
    step(5);
    Reset = 0;
    #1 check_all_zero("mid_press_reset");
    check("no_pulse_before_reset", run_np - np0, 0);
    step(2);
    Reset = 1; c = cyc;
    step(20);
    check("post_reset_pulses", run_np - np0, 1);
    check("post_reset_latency", run_pc, c + 8);
    io.Run_key = 1;
    step(20);
    np0 = run_np; f0 = run_falls;
    io.Run_key = 0; step(15);
    io.Run_key = 1; step(2);
    check("held_dip_held", int'(io.Run_held), 1);
    io.Run_key = 0; step(15);
    check("held_dip_falls", run_falls - f0, 0);
    io.Run_key = 1; step(20);
    check("held_dip_pulses", run_np - np0, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) io.Run_key = ~io.Run_key;
      if ($urandom_range(0, 4) == 0) io.Continue_key = ~io.Continue_key;
      io.SW_raw = W'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        Reset = 0;
        step($urandom_range(1, 3));
        Reset = 1;
      end
      step($urandom_range(0, 1) == 0 ? 1 : $urandom_range(2, 9));
    end
    io.Run_key = 1; io.Continue_key = 1;
    step(30);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
